// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the Viterbi ACS datapath: default code, parity and soft branch metric.
package viterbi_pkg;
  localparam int K_DEF    = 3;
  localparam int S_W_DEF  = K_DEF - 1;
  localparam int PM_W_DEF = 7;
  localparam int BM_MAX_W = 16;
  localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
  localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

  function automatic int s_w(input int k);
    return k - 1;
  endfunction

  function automatic logic parity(input logic [31:0] r, input logic [31:0] g);
    return ^(r & g);
  endfunction

  // Distance of soft symbol y from expected code bit c (all-ones = strong 1).
  function automatic logic [BM_MAX_W-1:0] soft_bm(input logic c, input logic [BM_MAX_W-1:0] y,
                                                  input int sw);
    logic [BM_MAX_W-1:0] ymax;
    ymax = BM_MAX_W'((1 << sw) - 1);
    return c ? (ymax - y) : y;
  endfunction

  // Survivor beat layout for the default code geometry.
  typedef struct packed {
    logic [S_W_DEF-1:0]  state;
    logic [PM_W_DEF-1:0] pm;
    logic [S_W_DEF-1:0]  addr;
    logic                sel;
    logic                dec;
    logic                norm;
  } surv_beat_t;
endpackage

// File: rtl/acs_bmu.sv
// Expected code pair and branch metric for one predecessor of a target state.
module acs_bmu
  import viterbi_pkg::*;
#(
  parameter int             K      = K_DEF,
  parameter logic [K-1:0]   G0     = G0_DEF,
  parameter logic [K-1:0]   G1     = G1_DEF,
  parameter int             SOFT_W = 1
) (
  input  logic [K-2:0]    state,
  input  logic            pred_lsb,
  input  logic [SOFT_W-1:0] sym0,
  input  logic [SOFT_W-1:0] sym1,
  output logic [SOFT_W:0] bm
);
  // Encoder register at the transition: {u, predecessor} == {target state, predecessor lsb}.
  logic [K-1:0] r;
  logic         c0, c1;

  assign r  = {state, pred_lsb};
  assign c0 = parity(32'(r), 32'(G0));
  assign c1 = parity(32'(r), 32'(G1));
  assign bm = (SOFT_W+1)'(soft_bm(c0, BM_MAX_W'(sym0), SOFT_W))
            + (SOFT_W+1)'(soft_bm(c1, BM_MAX_W'(sym1), SOFT_W));
endmodule

// File: rtl/acs_pipe.sv
// Two-stage add-compare-select with valid/ready and survivor saturation.
// Optional metric normalisation enabled by defining ACS_NORM_EN.
module acs_pipe
  import viterbi_pkg::*;
#(
  parameter int           K      = K_DEF,
  parameter logic [K-1:0] G0     = G0_DEF,
  parameter logic [K-1:0] G1     = G1_DEF,
  parameter int           SOFT_W = 1,
  parameter int           PM_W   = PM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-2:0]      state_in,
  input  logic [SOFT_W-1:0] sym0,
  input  logic [SOFT_W-1:0] sym1,
  input  logic [PM_W-1:0]   pm_in0,
  input  logic [PM_W-1:0]   pm_in1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-2:0]      state_out,
  output logic [PM_W-1:0]   pm_out,
  output logic [K-2:0]      addr_out,
  output logic              sel_out,
  output logic              dec_out,
  output logic              norm_out
);
  localparam int S_W    = s_w(K);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [S_W-1:0]  state;
    logic [PM_W-1:0] pm;
    logic [S_W-1:0]  addr;
    logic            sel;
    logic            dec;
    logic            norm;
  } surv_t;

  logic              en;
  logic [STAGES:0]   vld_pipe;
  logic [SOFT_W:0]   bm0, bm1;
  logic [S_W-1:0]    s1_state;
  logic [PM_W:0]     cand0, cand1, win, win_n;
  logic              sel, norm;
  surv_t             nxt, q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  acs_bmu #(.K(K), .G0(G0), .G1(G1), .SOFT_W(SOFT_W)) u_bmu[1:0] (
    .state    (state_in),
    .pred_lsb (2'b10),
    .sym0     (sym0),
    .sym1     (sym1),
    .bm       ({bm1, bm0})
  );

  always_comb begin
    sel   = cand1 < cand0;
    win   = sel ? cand1 : cand0;
    norm  = 1'b0;
    win_n = win;
`ifdef ACS_NORM_EN
    // Both candidates in the upper half: shift survivor down, flag for the controller.
    if (cand0[PM_W] || cand0[PM_W-1]) begin
      if (cand1[PM_W] || cand1[PM_W-1]) begin
        norm  = 1'b1;
        win_n = win - (PM_W+1)'(1 << (PM_W-1));
      end
    end
`endif
    nxt.state = s1_state;
    nxt.pm    = win_n[PM_W] ? '1 : win_n[PM_W-1:0];
    nxt.addr  = {s1_state[S_W-2:0], sel};
    nxt.sel   = sel;
    nxt.dec   = s1_state[S_W-1];
    nxt.norm  = norm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_state <= '0;
      cand0    <= '0;
      cand1    <= '0;
      q        <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_state <= state_in;
      cand0    <= {1'b0, pm_in0} + (PM_W+1)'(bm0);
      cand1    <= {1'b0, pm_in1} + (PM_W+1)'(bm1);
      q        <= nxt;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign state_out = q.state;
  assign pm_out    = q.pm;
  assign addr_out  = q.addr;
  assign sel_out   = q.sel;
  assign dec_out   = q.dec;
  assign norm_out  = q.norm;
endmodule

// File: tb/tb_acs_pipe.sv
// Scoreboard bench for acs_pipe: default K=3 hard-decision unit plus a K=5 3-bit soft unit.
module tb_acs_pipe;
  localparam logic [4:0] G0_K5 = 5'b10011;
  localparam logic [4:0] G1_K5 = 5'b11101;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_iv, a_ir, a_ov, a_or, a_sel, a_dec, a_norm, a_y0, a_y1;
  logic [1:0] a_st, a_sto, a_addr;
  logic [6:0] a_p0, a_p1, a_pm;

  logic       b_iv, b_ir, b_ov, b_or, b_sel, b_dec, b_norm;
  logic [3:0] b_st, b_sto, b_addr;
  logic [2:0] b_y0, b_y1;
  logic [6:0] b_p0, b_p1, b_pm;

  acs_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .state_in(a_st),
    .sym0(a_y0), .sym1(a_y1), .pm_in0(a_p0), .pm_in1(a_p1), .out_valid(a_ov),
    .out_ready(a_or), .state_out(a_sto), .pm_out(a_pm), .addr_out(a_addr),
    .sel_out(a_sel), .dec_out(a_dec), .norm_out(a_norm)
  );

  acs_pipe #(.K(5), .G0(G0_K5), .G1(G1_K5), .SOFT_W(3), .PM_W(7)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .state_in(b_st),
    .sym0(b_y0), .sym1(b_y1), .pm_in0(b_p0), .pm_in1(b_p1), .out_valid(b_ov),
    .out_ready(b_or), .state_out(b_sto), .pm_out(b_pm), .addr_out(b_addr),
    .sel_out(b_sel), .dec_out(b_dec), .norm_out(b_norm)
  );

  typedef struct {int st; int pm; int addr; int sel; int dec; int norm;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ma_act, ma_exp, mb_act, mb_exp;
  int checks = 0, failures = 0;

  function automatic exp_t mk(int st, int pm, int addr, int sel, int dec, int norm);
    exp_t e;
    e.st = st; e.pm = pm; e.addr = addr; e.sel = sel; e.dec = dec; e.norm = norm;
    return e;
  endfunction

  // Independent reference: walk the encoder taps bit by bit.
  function automatic exp_t model(int k, int g0, int g1, int sw, int pmw,
                                 int s, int y0, int y1, int p0, int p1);
    int cand[2];
    int ymax, r, c0, c1, w, sel, norm, half;
    ymax = (1 << sw) - 1;
    half = 1 << (pmw - 1);
    for (int b = 0; b < 2; b++) begin
      r = (s << 1) | b;
      c0 = 0; c1 = 0;
      for (int i = 0; i < k; i++) begin
        c0 = c0 ^ (((r & g0) >> i) & 1);
        c1 = c1 ^ (((r & g1) >> i) & 1);
      end
      cand[b] = ((b == 0) ? p0 : p1) + (c0 ? ymax - y0 : y0) + (c1 ? ymax - y1 : y1);
    end
    sel  = (cand[1] < cand[0]) ? 1 : 0;
    w    = cand[sel];
    norm = 0;
`ifdef ACS_NORM_EN
    if (cand[0] >= half && cand[1] >= half) begin
      w    = w - half;
      norm = 1;
    end
`endif
    if (w > (1 << pmw) - 1) w = (1 << pmw) - 1;
    return mk(s, w, ((s << 1) | sel) & ((1 << (k - 1)) - 1), sel, (s >> (k - 2)) & 1, norm);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a.st != e.st || a.pm != e.pm || a.addr != e.addr || a.sel != e.sel ||
        a.dec != e.dec || a.norm != e.norm) begin
      failures++;
      $display("FAIL %s actual st=%0d pm=%0d addr=%0d sel=%0d dec=%0d norm=%0d required st=%0d pm=%0d addr=%0d sel=%0d dec=%0d norm=%0d",
               nm, a.st, a.pm, a.addr, a.sel, a.dec, a.norm, e.st, e.pm, e.addr, e.sel, e.dec, e.norm);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_ov && a_or) begin
      ma_act = mk(int'(a_sto), int'(a_pm), int'(a_addr), int'(a_sel), int'(a_dec), int'(a_norm));
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_beat actual pm=%0d required none", a_pm);
      end else begin
        ma_exp = qa.pop_front();
        chk_beat("a_beat", ma_act, ma_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ov && b_or) begin
      mb_act = mk(int'(b_sto), int'(b_pm), int'(b_addr), int'(b_sel), int'(b_dec), int'(b_norm));
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_beat actual pm=%0d required none", b_pm);
      end else begin
        mb_exp = qb.pop_front();
        chk_beat("b_beat", mb_act, mb_exp);
      end
    end
  end

  task automatic send_a(input int s, input int y0, input int y1, input int p0, input int p1,
                        input exp_t e);
    bit ok = 0;
    a_st = 2'(s); a_y0 = 1'(y0); a_y1 = 1'(y1); a_p0 = 7'(p0); a_p1 = 7'(p1); a_iv = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = a_ir;
      @(posedge clk);
    end
    #1;
    if (ok) qa.push_back(e);
    else chk("a_send_timeout", 0, 1);
    a_iv = 1'b0;
  endtask

  task automatic send_b(input int s, input int y0, input int y1, input int p0, input int p1,
                        input exp_t e);
    bit ok = 0;
    b_st = 4'(s); b_y0 = 3'(y0); b_y1 = 3'(y1); b_p0 = 7'(p0); b_p1 = 7'(p1); b_iv = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = b_ir;
      @(posedge clk);
    end
    #1;
    if (ok) qb.push_back(e);
    else chk("b_send_timeout", 0, 1);
    b_iv = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) chk("drain_timeout", qa.size() + qb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_iv = 0; a_or = 1; a_st = 0; a_y0 = 0; a_y1 = 0; a_p0 = 0; a_p1 = 0;
    b_iv = 0; b_or = 1; b_st = 0; b_y0 = 0; b_y1 = 0; b_p0 = 0; b_p1 = 0;
    #12;
    chk("rst_out_valid", int'(a_ov), 0);
    chk("rst_pm_out", int'(a_pm), 0);
    chk("rst_in_ready", int'(a_ir), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1-T3: directed K=3 beats
    send_a(0, 0, 0, 5, 9, mk(0, 5, 0, 0, 0, 0));
    send_a(2, 1, 1, 20, 20, mk(2, 20, 0, 0, 1, 0));
    send_a(0, 1, 0, 10, 10, mk(0, 11, 0, 0, 0, 0));
`ifdef ACS_NORM_EN
    send_a(0, 1, 0, 127, 127, mk(0, 64, 0, 0, 0, 1));
`else
    send_a(0, 1, 0, 127, 127, mk(0, 127, 0, 0, 0, 0));
`endif
    drain();

    // T4: back-to-back with a 3-cycle downstream stall on the first output
    fork
      begin
        send_a(1, 0, 1, 3, 4, mk(1, 4, 3, 1, 0, 0));
        send_a(3, 0, 0, 8, 2, mk(3, 3, 3, 1, 1, 0));
        send_a(2, 1, 0, 6, 6, mk(2, 7, 0, 0, 1, 0));
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk); #1;
          seen = a_ov;
        end
        if (!seen) chk("stall_wait_timeout", 0, 1);
        a_or = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", int'(a_ir), 0);
          chk("stall_out_valid", int'(a_ov), 1);
          chk("stall_pm_frozen", int'(a_pm), 4);
          chk("stall_state_frozen", int'(a_sto), 1);
        end
        @(posedge clk); #1;
        a_or = 1'b1;
      end
    join
    drain();

    // T5: reset with two beats in flight
    a_or = 1'b0;
    send_a(0, 0, 0, 5, 9, mk(0, 5, 0, 0, 0, 0));
    send_a(2, 1, 1, 20, 20, mk(2, 20, 0, 0, 1, 0));
    chk("t5_pre_valid", int'(a_ov), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", int'(a_ov), 0);
    chk("t5_rst_pm_out", int'(a_pm), 0);
    chk("t5_rst_in_ready", int'(a_ir), 1);
    qa.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_or = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_stale", int'(a_ov), 0);
    @(posedge clk); #1;

    // T6: K=5 soft unit, directed extremes then full state sweep
    send_b(0, 7, 7, 100, 10, mk(0, 10, 1, 1, 0, 0));
    send_b(0, 0, 0, 100, 10, mk(0, 24, 1, 1, 0, 0));
    for (int s = 0; s < 16; s++) begin
      int y0, y1, p0, p1;
      y0 = (s * 3) % 8;
      y1 = (s * 5 + 2) % 8;
      p0 = (s * 37) % 128;
      p1 = (s * 53 + 60) % 128;
      send_b(s, y0, y1, p0, p1, model(5, int'(G0_K5), int'(G1_K5), 3, 7, s, y0, y1, p0, p1));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
